acq_window_sched: RTL and testbench
===================================

Name: acq_window_sched

Overview:
Measurement window scheduler for the phase-noise analyzer. It owns an internal tick divider, which turns the 50 MHz system clock into a tick strobe. On command it re-phases that divider and sequences one acquisition run: a settle interval, then a series of contiguous gate windows of programmable tick length. The gate and window strobes drive the downstream phase sampler and accumulators.

Parameters:
TICK_DIV, 50, tick period in clk_i cycles (50 MHz / 50 = 1 MHz tick); legal range 2..2^24-1
IDX_W, 8, width of the window index counter

Ports:
clk_i  in  1  system clock, 50 MHz
reset_ni  in  1  asynchronous, active-low reset
start_i  in  1  start request; accepted only in IDLE
abort_i  in  1  abort request; honoured in any state
settle_ticks_i  in  16  settle interval length in ticks; 0 means no settle interval
gate_ticks_i  in  24  window length in ticks; 0 is treated as 1
num_windows_i  in  IDX_W  windows per run; 0 means continuous until abort
tick_o  in  out  1  divider tick strobe, one clk_i cycle wide
busy_o  out  1  run in progress
gate_o  out  1  acquisition gate
window_start_o  out  1  1-cycle pulse at the start of each window
window_end_o  out  1  1-cycle pulse at the end of each window
window_idx_o  out  IDX_W  index of the current window
done_o  out  1  1-cycle pulse at normal completion of a run
aborted_o  out  1  1-cycle pulse when a run is aborted

Behaviour:
- Reset (asynchronous, reset_ni=0): all outputs 0, divider count 0, FSM in IDLE.
- Divider:
  - Count runs 0..TICK_DIV-1 and wraps to 0; tick_o=1 when count==0.
  - It free-runs in every state.
  - A clear forces count to 0 at the next edge, so tick_o is high in the cycle after the clear.
- FSM states: IDLE, SETTLE, GATE, DONE.
- Start acceptance:
  - A start is accepted when state is IDLE, start_i=1 and abort_i=0; start_i is ignored in all other states.
  - The accept edge latches settle_ticks_i, gate_ticks_i and num_windows_i, clears the divider, and enters SETTLE.
  - busy_o rises in the next cycle.
- Tick numbering: ticks after accept are indexed n=0,1,2…; tick 0 is the first cycle after accept.
- SETTLE:
  - Counts ticks; at tick n=settle the FSM enters GATE.
  - With settle=0 this happens at tick 0.
- GATE:
  - Window k starts at tick settle+k·G and ends at tick settle+(k+1)·G, where G is the latched gate length (minimum 1).
  - Outputs are registered and change in the cycle after the triggering tick.
  - gate_o rises with window 0 and stays high across window boundaries, with no gap.
  - At a boundary tick: window_end_o pulses; if another window follows, window_start_o pulses in the same cycle and window_idx_o increments.
- Run completion:
  - After the end of window num_windows-1, gate_o falls, done_o pulses and busy_o falls, all in the same cycle; the FSM then passes through DONE to IDLE.
  - window_idx_o holds its last value until the next accepted start, which resets it to 0.
- Continuous mode (num_windows=0): windows repeat until abort; window_idx_o wraps from 2^IDX_W-1 to 0.
- Abort:
  - abort_i=1 in SETTLE or GATE: in the next cycle gate_o=0, busy_o=0, aborted_o=1 and the FSM returns to IDLE.
  - No done_o and no window_end_o pulse for the truncated window.
  - abort_i in IDLE: no effect, no aborted_o.
  - start_i and abort_i both high in IDLE: abort wins and nothing starts.
- Simultaneous events:
  - abort_i on a boundary tick: abort wins and no window strobes are issued.
  - The settle and gate tick counters saturate-compare; there is no arithmetic wrap inside a window.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0 and no done_o or aborted_o pulse.

Decomposition:
- Package acq_pkg holds:
  - FSM state enum
  - the gate-length, settle-length and index widths as localparams
  - the default tick divider constant 50
- Sub-module acq_tick_div:
  - parameter TICK_DIV
  - ports clk_i, reset_ni, clr_i, tick_o
  - instantiated once inside acq_window_sched.

Test Plan:
- Basic run: TICK_DIV=4, settle=2, gate=3, num=2, start at cycle 0 -> ticks at cycles 1,5,9…; busy_o high from cycle 1; window_start_o at cycles 10 and 22; window_end_o at 22 and 34; gate_o high 10..33; done_o pulse and busy_o low at cycle 34; window_idx_o 0 then 1.
- Zero settle and zero gate: TICK_DIV=4, settle=0, gate=0, num=3 -> gate_o high cycles 2..13; window_start_o at 2, 6, 10; done_o at 14.
- Abort mid-window: basic run with abort_i at cycle 15 -> gate_o=0, busy_o=0, aborted_o=1 at cycle 16; no done_o; a new start at cycle 20 is accepted.
- Ignored and conflicting commands: start_i pulsed during GATE -> no effect on timing; start_i and abort_i together in IDLE -> busy_o stays 0 and aborted_o stays 0.
- Continuous mode with wrap: IDX_W=2, num=0, gate=1 -> window_idx_o sequence 0,1,2,3,0; done_o never asserts; abort ends the run.
- Asynchronous reset: reset_ni low mid-GATE between clock edges -> all outputs 0 immediately; after release, IDLE and tick_o free-running.

Source files
------------

// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acq_pkg
//  Purpose  : Shared types and constants for the acquisition window scheduler
//  Revision : 1.0 - initial release
// ============================================================================
package acq_pkg;

  // Width of the latched gate-window length (in ticks)
  localparam int unsigned c_GATE_W       = 24;
  // Width of the latched settle-interval length (in ticks)
  localparam int unsigned c_SETTLE_W     = 16;
  // Default width of the window index counter
  localparam int unsigned c_DEF_IDX_W    = 8;
  // Default tick divider: 50 MHz / 50 = 1 MHz tick
  localparam int unsigned c_DEF_TICK_DIV = 50;

  // Run sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } acq_state_e;

  // Window length minus one, with a requested length of 0 treated as 1.
  // Storing length-1 lets the gate counter compare without ever exceeding it.
  function automatic logic [c_GATE_W-1:0] gate_len_m1(input logic [c_GATE_W-1:0] len);
    return (len == '0) ? '0 : (len - c_GATE_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/acq_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : acq_tick_div
//  Purpose  : Free-running tick divider with synchronous re-phase (clear)
//  Revision : 1.0 - initial release
// ============================================================================
module acq_tick_div #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned          c_CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_tick;

  // Next count: clear wins, otherwise count 0..TICK_DIV-1 and wrap
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_i) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == c_CNT_MAX) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + c_CNT_W'(1);
    end
  end

  // Count register; the strobe is registered alongside so it is high exactly
  // while the count is 0, yet stays low while reset holds everything at 0
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == '0);
    end
  end

  assign tick_o = r_tick;

endmodule
`default_nettype wire

// File: rtl/acq_window_sched.sv
`default_nettype none
// ============================================================================
//  Module   : acq_window_sched
//  Purpose  : Measurement window scheduler - settle interval followed by a
//             series of contiguous, tick-timed acquisition gate windows
//  Revision : 1.0 - initial release
// ============================================================================
module acq_window_sched
  import acq_pkg::*;
#(
  parameter int unsigned TICK_DIV = c_DEF_TICK_DIV,
  parameter int unsigned IDX_W    = c_DEF_IDX_W
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [c_SETTLE_W-1:0] settle_ticks_i,
  input  logic [c_GATE_W-1:0]   gate_ticks_i,
  input  logic [IDX_W-1:0]      num_windows_i,
  output logic                  tick_o,
  output logic                  busy_o,
  output logic                  gate_o,
  output logic                  window_start_o,
  output logic                  window_end_o,
  output logic [IDX_W-1:0]      window_idx_o,
  output logic                  done_o,
  output logic                  aborted_o
);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  acq_state_e              r_state,    w_state_nxt;
  logic [c_SETTLE_W-1:0]   r_settle,   w_settle_nxt;
  logic [c_GATE_W-1:0]     r_gate_m1,  w_gate_m1_nxt;
  logic [IDX_W-1:0]        r_num,      w_num_nxt;
  logic [c_SETTLE_W-1:0]   r_tcnt,     w_tcnt_nxt;
  logic [c_GATE_W-1:0]     r_gcnt,     w_gcnt_nxt;
  logic                    r_busy,     w_busy_nxt;
  logic                    r_gate,     w_gate_nxt;
  logic                    r_wstart,   w_wstart_nxt;
  logic                    r_wend,     w_wend_nxt;
  logic [IDX_W-1:0]        r_idx,      w_idx_nxt;
  logic                    r_done,     w_done_nxt;
  logic                    r_aborted,  w_aborted_nxt;

  logic                    w_clr;
  logic                    w_tick;
  logic                    w_last_win;

  // Tick divider, re-phased on every accepted start
  acq_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (w_clr),
    .tick_o   (w_tick)
  );

  // The current window is the last one only in counted (non-continuous) mode
  assign w_last_win = (r_num != '0) && (r_idx == (r_num - IDX_W'(1)));

  // Next-state and next-output decode; abort has priority over every tick event
  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle;
    w_gate_m1_nxt = r_gate_m1;
    w_num_nxt     = r_num;
    w_tcnt_nxt    = r_tcnt;
    w_gcnt_nxt    = r_gcnt;
    w_busy_nxt    = r_busy;
    w_gate_nxt    = r_gate;
    w_idx_nxt     = r_idx;
    w_wstart_nxt  = 1'b0;
    w_wend_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_clr         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          w_settle_nxt  = settle_ticks_i;
          w_gate_m1_nxt = gate_len_m1(gate_ticks_i);
          w_num_nxt     = num_windows_i;
          w_tcnt_nxt    = '0;
          w_idx_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_clr         = 1'b1;
          w_state_nxt   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort_i) begin
          w_busy_nxt    = 1'b0;
          w_gate_nxt    = 1'b0;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (w_tick) begin
          if (r_tcnt >= r_settle) begin
            // Window 0 opens on tick n == settle
            w_gate_nxt   = 1'b1;
            w_wstart_nxt = 1'b1;
            w_idx_nxt    = '0;
            w_gcnt_nxt   = '0;
            w_state_nxt  = ST_GATE;
          end else begin
            w_tcnt_nxt = r_tcnt + c_SETTLE_W'(1);
          end
        end
      end

      ST_GATE: begin
        if (abort_i) begin
          w_busy_nxt    = 1'b0;
          w_gate_nxt    = 1'b0;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (w_tick) begin
          if (r_gcnt >= r_gate_m1) begin
            // Window boundary: close this window and open the next, if any
            w_wend_nxt = 1'b1;
            if (w_last_win) begin
              w_gate_nxt  = 1'b0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_wstart_nxt = 1'b1;
              w_idx_nxt    = r_idx + IDX_W'(1);
              w_gcnt_nxt   = '0;
            end
          end else begin
            w_gcnt_nxt = r_gcnt + c_GATE_W'(1);
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, configuration, counters and registered outputs
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= ST_IDLE;
      r_settle  <= '0;
      r_gate_m1 <= '0;
      r_num     <= '0;
      r_tcnt    <= '0;
      r_gcnt    <= '0;
      r_busy    <= 1'b0;
      r_gate    <= 1'b0;
      r_wstart  <= 1'b0;
      r_wend    <= 1'b0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_settle  <= w_settle_nxt;
      r_gate_m1 <= w_gate_m1_nxt;
      r_num     <= w_num_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_busy    <= w_busy_nxt;
      r_gate    <= w_gate_nxt;
      r_wstart  <= w_wstart_nxt;
      r_wend    <= w_wend_nxt;
      r_idx     <= w_idx_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign tick_o         = w_tick;
  assign busy_o         = r_busy;
  assign gate_o         = r_gate;
  assign window_start_o = r_wstart;
  assign window_end_o   = r_wend;
  assign window_idx_o   = r_idx;
  assign done_o         = r_done;
  assign aborted_o      = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_acq_window_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acq_window_sched
//  Purpose  : Directed, scoreboard-based bench for acq_window_sched
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acq_window_sched;

  localparam int DIV = 4;
  localparam int IW  = 2;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic [15:0]   settle   = '0;
  logic [23:0]   gate_len = '0;
  logic [IW-1:0] num      = '0;

  logic          tick, busy, gate, wstart, wend, done, aborted;
  logic [IW-1:0] idx;
  logic [8:0]    w_obs;

  int checks   = 0;
  int failures = 0;

  // Expected output vectors, one per cycle of a run
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  acq_window_sched #(
    .TICK_DIV (DIV),
    .IDX_W    (IW)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .start_i        (start),
    .abort_i        (abort),
    .settle_ticks_i (settle),
    .gate_ticks_i   (gate_len),
    .num_windows_i  (num),
    .tick_o         (tick),
    .busy_o         (busy),
    .gate_o         (gate),
    .window_start_o (wstart),
    .window_end_o   (wend),
    .window_idx_o   (idx),
    .done_o         (done),
    .aborted_o      (aborted)
  );

  // {tick, busy, gate, wstart, wend, done, aborted, idx}
  assign w_obs = {tick, busy, gate, wstart, wend, done, aborted, idx};

  // Window index the spec predicts for cycle c of a run
  function automatic int idx_at(int c, int s0, int per, int n);
    int k;
    if (c < s0) return 0;
    k = (c - s0) / per;
    if (n != 0 && k > n - 1) k = n - 1;
    return k % (1 << IW);
  endfunction

  // Closed-form expectation for cycle c after accept (accept edge ends cycle 0)
  function automatic logic [8:0] exp_at(int c, int st, int g, int n, int ab);
    int   gg, per, s0, d, kb, ix;
    logic tk, bz, gt, ws, we, dn, ao, bnd;
    logic [IW-1:0] ixv;
    gg  = (g == 0) ? 1 : g;
    per = gg * DIV;
    s0  = 2 + st * DIV;
    d   = (n == 0) ? 32'h7fff_ffff : s0 + n * per;
    tk  = (((c - 1) % DIV) == 0);
    if (ab >= 0 && c > ab) begin
      bz = 1'b0; gt = 1'b0; ws = 1'b0; we = 1'b0; dn = 1'b0;
      ao = (c == ab + 1);
      ix = idx_at(ab, s0, per, n);
    end else begin
      bnd = (c >= s0) && (((c - s0) % per) == 0);
      kb  = (c >= s0) ? (c - s0) / per : -1;
      bz  = (c < d);
      gt  = (c >= s0) && (c < d);
      ws  = bnd && (n == 0 || kb < n);
      we  = bnd && (kb >= 1) && (n == 0 || kb <= n);
      dn  = (c == d);
      ao  = 1'b0;
      ix  = idx_at(c, s0, per, n);
    end
    ixv = IW'(ix);
    return {tk, bz, gt, ws, we, dn, ao, ixv};
  endfunction

  // Compare one observed vector with one expected vector
  task automatic check(input string tag, input int c, input logic [8:0] o, input logic [8:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b (tick,busy,gate,ws,we,done,abrt,idx)", tag, c, o, e);
    end
  endtask

  // One run: called just after a rising edge; that cycle is cycle 0 (start).
  // sp = cycle of an extra start pulse, ab = cycle of an abort pulse (-1 none)
  task automatic run_scn(input string tag, input int st, input int g, input int n,
                         input int ab, input int sp, input int ncyc);
    logic [8:0] e;
    for (int c = 1; c <= ncyc; c++) sb_q.push_back(exp_at(c, st, g, n, ab));
    settle   = 16'(st);
    gate_len = 24'(g);
    num      = IW'(n);
    start    = 1'b1;
    abort    = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == sp);
      abort = (c == ab);
      if (c == 1) begin
        // Inputs are latched at accept; later changes must not matter
        settle   = 16'd7;
        gate_len = 24'd9;
        num      = IW'(1);
      end
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s cyc=%0d observed=empty-scoreboard expected=entry", tag, c);
      end else begin
        e = sb_q.pop_front();
        check(tag, c, w_obs, e);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int tcount;

    // Reset state
    #12;
    check("reset_state", 0, w_obs, 9'h000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // start+abort together in IDLE: nothing starts
    start = 1'b1; abort = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("idle_start_abort", c, w_obs & 9'h0FC, 9'h000);
    end
    // abort alone in IDLE: no aborted pulse
    abort = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      check("idle_abort", c, w_obs & 9'h0FC, 9'h000);
    end

    // Basic run with a stray start pulse during GATE
    run_scn("basic",        2, 3, 2, -1, 12, 38);
    // Zero settle, zero gate (treated as 1)
    run_scn("zero",         0, 0, 3, -1, -1, 18);
    // Abort mid-window, then a new start at cycle 20
    run_scn("abort_mid",    2, 3, 2, 15, -1, 19);
    run_scn("restart",      2, 3, 2, -1, -1, 38);
    // Abort during SETTLE
    run_scn("abort_settle", 3, 1, 1,  4, -1,  8);
    // Abort exactly on a window boundary tick
    run_scn("abort_bnd",    2, 3, 2, 21, -1, 25);
    // Single window after a short settle
    run_scn("single",       1, 2, 1, -1, -1, 17);
    // Continuous mode with index wrap, ended by abort
    run_scn("continuous",   0, 1, 0, 20, -1, 24);

    // Asynchronous reset mid-GATE
    run_scn("rst_pre",      2, 3, 2, -1, -1, 12);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 0, w_obs, 9'h000);
    @(posedge clk); #1;
    check("reset_hold", 1, w_obs, 9'h000);
    #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tcount = 0;
    for (int c = 1; c <= 16; c++) begin
      if (tick) tcount++;
      check("post_reset_idle", c, w_obs & 9'h0FF, 9'h000);
      @(posedge clk); #1;
    end
    checks++;
    assert (tcount == 4) else begin
      failures++;
      $error("FAIL post_reset_ticks observed=%0d expected=4", tcount);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
